// File: rtl/pp_tx_pkg.sv
// Shared types and constants for the ping-pong frame RAM transmit reader.
package pp_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_LEN  = 4'd1,
    ST_LD_LEN  = 4'd2,
    ST_RD_BYTE = 4'd3,
    ST_LD_BYTE = 4'd4,
    ST_SEND    = 4'd5,
    ST_CRC_LO  = 4'd6,
    ST_CRC_HI  = 4'd7,
    ST_DONE    = 4'd8
  } pp_tx_state_e;

  localparam int          HDR_LEN_DEF = 3;
  localparam int          LEN_OFS     = 2;
  localparam logic [15:0] CRC16_POLY  = 16'hA001;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC16/MODBUS update of one byte, LSB first.
// Only compiled when PP_TX_CRC_EN is defined.
`ifdef PP_TX_CRC_EN
module crc16_byte
  import pp_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC16_POLY) : (crc_out >> 1);
    end
  end

endmodule
`endif

// File: rtl/pp_tx_reader.sv
// Read side of the ping-pong frame RAM: fetches [src, dst, len, data] and streams it on valid/ready.
// Define PP_TX_CRC_EN to append a CRC16/MODBUS (low byte first) after the RAM bytes.
module pp_tx_reader
  import pp_tx_pkg::*;
#(
  parameter int A_WIDTH = 6,
  parameter int HDR_LEN = HDR_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               unread,
  input  logic [7:0]         rd_flags,
  input  logic [7:0]         rd_byte,
  output logic [A_WIDTH+1:0] rd_addr,
  output logic               rd_en,
  output logic               rd_done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [7:0]         tx_flags,
  input  logic               abort,
  output logic               len_err,
  output logic               busy
);

  localparam int              AW        = A_WIDTH + 2;
  localparam int              CW        = (A_WIDTH + 3 > 9) ? A_WIDTH + 3 : 9;
  localparam logic [CW-1:0]   BUF_BYTES = CW'(2 ** AW);
  localparam logic [CW-1:0]   HDR_W     = CW'(HDR_LEN);
  localparam logic [AW-1:0]   LEN_ADDR  = AW'(HDR_LEN - 1);

  pp_tx_state_e  state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] total_calc;
  logic [7:0]    data_q, data_d;
  logic [7:0]    flags_q, flags_d;
  logic          last_byte;
  logic          len_bad;

  // Counter is wide enough that HDR_LEN + 255 never wraps before the size check.
  assign total_calc = HDR_W + CW'(rd_byte);
  assign len_bad    = (total_calc > BUF_BYTES);
  assign last_byte  = (idx_q == total_q - CW'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    total_d = total_q;
    data_d  = data_q;
    flags_d = flags_q;
    len_err = 1'b0;
    if (state_q == ST_IDLE) begin
      if (unread) begin
        flags_d = rd_flags;
        state_d = ST_RD_LEN;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (abort) begin
      // Routing through DONE gives the release pulse while unread is still stable.
      state_d = ST_DONE;
    end else if (!unread) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RD_LEN:  state_d = ST_LD_LEN;
        ST_LD_LEN: begin
          if (len_bad) begin
            len_err = 1'b1;
            state_d = ST_IDLE;
          end else begin
            total_d = total_calc;
            idx_d   = '0;
            state_d = ST_RD_BYTE;
          end
        end
        ST_RD_BYTE: state_d = ST_LD_BYTE;
        ST_LD_BYTE: begin
          data_d  = rd_byte;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (last_byte) begin
`ifdef PP_TX_CRC_EN
              state_d = ST_CRC_LO;
`else
              state_d = ST_DONE;
`endif
            end else begin
              idx_d   = idx_q + CW'(1);
              state_d = ST_RD_BYTE;
            end
          end
        end
`ifdef PP_TX_CRC_EN
        ST_CRC_LO: if (tx_ready) state_d = ST_CRC_HI;
        ST_CRC_HI: if (tx_ready) state_d = ST_DONE;
`endif
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      total_q <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

`ifdef PP_TX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;

  crc16_byte u_crc (
    .crc_in  (crc_q),
    .byte_in (data_q),
    .crc_out (crc_next)
  );

  // Folds in each RAM byte exactly on the edge it is accepted.
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_IDLE && unread) begin
      crc_d = CRC16_INIT;
    end else if (state_q == ST_SEND && tx_ready && !abort && unread) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign tx_valid = (state_q == ST_SEND) || (state_q == ST_CRC_LO) || (state_q == ST_CRC_HI);
  assign tx_last  = (state_q == ST_CRC_HI);
  assign tx_data  = (state_q == ST_CRC_LO) ? crc_q[7:0] :
                    (state_q == ST_CRC_HI) ? crc_q[15:8] : data_q;
`else
  assign tx_valid = (state_q == ST_SEND);
  assign tx_last  = (state_q == ST_SEND) && last_byte;
  assign tx_data  = data_q;
`endif

  assign rd_en    = (state_q == ST_RD_LEN) || (state_q == ST_RD_BYTE);
  assign rd_addr  = (state_q == ST_RD_LEN)  ? LEN_ADDR :
                    (state_q == ST_RD_BYTE) ? idx_q[AW-1:0] : '0;
  assign rd_done  = (state_q == ST_DONE) || len_err;
  assign busy     = (state_q != ST_IDLE);
  assign tx_flags = flags_q;

endmodule

// File: tb/tb_pp_tx_reader.sv
// Scoreboard bench for pp_tx_reader with a two-slot behavioural frame RAM.
// Expected bytes include the CRC trailer when PP_TX_CRC_EN is defined.
module tb_pp_tx_reader;

  logic       clk;
  logic       reset_n;
  logic       unread;
  logic [7:0] rd_flags;
  logic [7:0] rd_byte;
  logic [7:0] rd_addr;
  logic       rd_en;
  logic       rd_done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic [7:0] tx_flags;
  logic       abort;
  logic       len_err;
  logic       busy;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
    logic [7:0] flags;
  } exp_t;

  typedef struct packed {
    logic        last;
    logic [7:0]  data;
    logic [7:0]  flags;
    logic [31:0] cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   obs_rd = 0;
  int   total  = 0;
  int   bad    = 0;

  logic [7:0] mem [2][256];
  logic [7:0] flg [2];
  int         loaded   = 0;
  int         released = 0;

  logic [31:0] cyc           = 0;
  int          done_cnt      = 0;
  int          lerr_cnt      = 0;
  int          lerr_done_cnt = 0;
  int          valid_cnt     = 0;
  int          stab_err      = 0;
  logic        prev_hold     = 1'b0;
  logic [7:0]  prev_data     = 8'h00;

  pp_tx_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .unread   (unread),
    .rd_flags (rd_flags),
    .rd_byte  (rd_byte),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .rd_done  (rd_done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .tx_flags (tx_flags),
    .abort    (abort),
    .len_err  (len_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM: one-cycle read latency, buffer released on rd_done.
  assign unread   = (loaded != released);
  assign rd_flags = flg[released[0]];

  always @(posedge clk) begin
    if (rd_en) rd_byte <= mem[released[0]][rd_addr];
    if (rd_done) released <= released + 1;
  end

  // Passive monitor: records accepted bytes and protocol events at the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && tx_valid && tx_ready && !abort)
      obs_q.push_back({tx_last, tx_data, tx_flags, cyc});
    if (rd_done) done_cnt <= done_cnt + 1;
    if (len_err) lerr_cnt <= lerr_cnt + 1;
    if (len_err && rd_done) lerr_done_cnt <= lerr_done_cnt + 1;
    if (tx_valid) valid_cnt <= valid_cnt + 1;
    if (prev_hold && tx_valid && tx_data !== prev_data) stab_err <= stab_err + 1;
    prev_hold <= tx_valid && !tx_ready;
    prev_data <= tx_data;
  end

`ifdef PP_TX_CRC_EN
  function automatic logic [15:0] crc16_model(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
`endif

  task automatic load_buffer(input logic [7:0] flags, input logic [7:0] b[$]);
    foreach (b[i]) mem[loaded[0]][i] = b[i];
    flg[loaded[0]] = flags;
    loaded = loaded + 1;
  endtask

  task automatic push_exp(input logic [7:0] flags, input logic [7:0] b[$], input int n);
    logic lst;
    for (int i = 0; i < n; i++) begin
`ifdef PP_TX_CRC_EN
      lst = 1'b0;
`else
      lst = (i == b.size() - 1);
`endif
      exp_q.push_back({lst, b[i], flags});
    end
`ifdef PP_TX_CRC_EN
    if (n == b.size()) begin
      logic [15:0] c;
      c = crc16_model(b);
      exp_q.push_back({1'b0, c[7:0], flags});
      exp_q.push_back({1'b1, c[15:8], flags});
    end
`endif
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    repeat (2) @(posedge clk); #1;
    outs = {tx_valid, tx_last, rd_en, rd_done, len_err, busy, tx_data, tx_flags, rd_addr};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", outs);
    end
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_no_unread: got busy=%b rd_en=%b, want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_basic();
    logic [7:0] f[$];
    exp_t e;
    obs_t o;
    bit   ok;
    int   base, done0;
    f = '{8'h05, 8'h00, 8'h02, 8'hAA, 8'h55};
    tx_ready = 1'b1;
    done0 = done_cnt;
    base  = obs_rd;
    push_exp(8'h5A, f, f.size());
    load_buffer(8'h5A, f);
    wait_done(done0 + 1, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL basic_done: got no rd_done, want 1 pulse");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin
        bad++;
        $display("[TB] FAIL basic_byte: got nothing, want %h", e.data);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if ({o.last, o.data, o.flags} !== e) begin
          bad++;
          $display("[TB] FAIL basic_byte: got last=%b data=%h flags=%h, want last=%b data=%h flags=%h",
                   o.last, o.data, o.flags, e.last, e.data, e.flags);
        end
      end
    end
    for (int i = 1; i < f.size(); i++) begin
      if (base + i < obs_q.size()) begin
        total++;
        if (obs_q[base+i].cyc - obs_q[base+i-1].cyc !== 32'd3) begin
          bad++;
          $display("[TB] FAIL basic_rate: got %0d cycles between bytes, want 3",
                   obs_q[base+i].cyc - obs_q[base+i-1].cyc);
        end
      end
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (done_cnt - done0 !== 1 || obs_rd != obs_q.size()) begin
      bad++;
      $display("[TB] FAIL basic_extra: got done=%0d extra=%0d, want 1 0",
               done_cnt - done0, obs_q.size() - obs_rd);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] f[$];
    exp_t e;
    obs_t o;
    bit   ok;
    int   done0, stab0;
    f = '{8'h05, 8'h00, 8'h02, 8'hAA, 8'h55};
    done0 = done_cnt;
    stab0 = stab_err;
    push_exp(8'h33, f, f.size());
    load_buffer(8'h33, f);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
      if (done_cnt > done0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL toggle_done: got no rd_done, want 1 pulse");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin
        bad++;
        $display("[TB] FAIL toggle_byte: got nothing, want %h", e.data);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if ({o.last, o.data, o.flags} !== e) begin
          bad++;
          $display("[TB] FAIL toggle_byte: got last=%b data=%h flags=%h, want last=%b data=%h flags=%h",
                   o.last, o.data, o.flags, e.last, e.data, e.flags);
        end
      end
    end
    total++;
    if (stab_err !== stab0) begin
      bad++;
      $display("[TB] FAIL toggle_stable: got %0d data changes while held, want 0", stab_err - stab0);
    end
  endtask

  task automatic test_len_err();
    logic [7:0] f[$];
    bit   ok;
    int   done0, lerr0, ld0, valid0, obs0;
    f = '{8'h01, 8'h02, 8'hFF};
    tx_ready = 1'b1;
    done0  = done_cnt;
    lerr0  = lerr_cnt;
    ld0    = lerr_done_cnt;
    valid0 = valid_cnt;
    obs0   = obs_q.size();
    load_buffer(8'h44, f);
    wait_done(done0 + 1, 100, ok);
    repeat (3) @(posedge clk); #1;
    total++;
    if (!ok || lerr_done_cnt - ld0 !== 1 || lerr_cnt - lerr0 !== 1) begin
      bad++;
      $display("[TB] FAIL len_err_pulse: got len_err=%0d with_done=%0d, want 1 1",
               lerr_cnt - lerr0, lerr_done_cnt - ld0);
    end
    total++;
    if (valid_cnt !== valid0 || obs_q.size() != obs0) begin
      bad++;
      $display("[TB] FAIL len_err_silent: got %0d valid cycles, want 0", valid_cnt - valid0);
    end
    total++;
    if (busy !== 1'b0 || done_cnt - done0 !== 1) begin
      bad++;
      $display("[TB] FAIL len_err_idle: got busy=%b done=%0d, want 0 1", busy, done_cnt - done0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] f[$];
    exp_t e;
    obs_t o;
    bit   ok;
    int   done0;
    f = '{8'h05, 8'h00, 8'h02, 8'hAA, 8'h55};
    tx_ready = 1'b0;
    done0 = done_cnt;
    push_exp(8'h66, f, 2);
    load_buffer(8'h66, f);
    for (int k = 0; k < 2; k++) begin
      wait_valid(50, ok);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    wait_valid(50, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL abort_third_byte: got tx_valid=0, want 1");
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (tx_valid !== 1'b0 || rd_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_release: got tx_valid=%b rd_done=%b, want 0 1", tx_valid, rd_done);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rd_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle: got busy=%b rd_done=%b, want 0 0", busy, rd_done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin
        bad++;
        $display("[TB] FAIL abort_byte: got nothing, want %h", e.data);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if ({o.last, o.data, o.flags} !== e) begin
          bad++;
          $display("[TB] FAIL abort_byte: got last=%b data=%h flags=%h, want last=%b data=%h flags=%h",
                   o.last, o.data, o.flags, e.last, e.data, e.flags);
        end
      end
    end
    total++;
    if (obs_rd != obs_q.size() || done_cnt - done0 !== 1) begin
      bad++;
      $display("[TB] FAIL abort_count: got extra=%0d done=%0d, want 0 1",
               obs_q.size() - obs_rd, done_cnt - done0);
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    exp_t e;
    obs_t o;
    bit   ok;
    int   done0;
    f1 = '{8'h01, 8'h02, 8'h02, 8'hC3, 8'h3C};
    f2 = '{8'h03, 8'h04, 8'h01, 8'h99};
    tx_ready = 1'b1;
    done0 = done_cnt;
    push_exp(8'h11, f1, f1.size());
    push_exp(8'h22, f2, f2.size());
    load_buffer(8'h11, f1);
    load_buffer(8'h22, f2);
    wait_done(done0 + 2, 300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL b2b_done: got %0d rd_done pulses, want 2", done_cnt - done0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin
        bad++;
        $display("[TB] FAIL b2b_byte: got nothing, want %h", e.data);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if ({o.last, o.data, o.flags} !== e) begin
          bad++;
          $display("[TB] FAIL b2b_byte: got last=%b data=%h flags=%h, want last=%b data=%h flags=%h",
                   o.last, o.data, o.flags, e.last, e.data, e.flags);
        end
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] f[$];
    logic [29:0] outs;
    exp_t e;
    obs_t o;
    bit   ok;
    int   done0;
    f = '{8'h07, 8'h08, 8'h01, 8'h3C};
    tx_ready = 1'b0;
    done0 = done_cnt;
    push_exp(8'h77, f, 1);
    load_buffer(8'h77, f);
    wait_valid(50, ok);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    wait_valid(50, ok);
    reset_n = 1'b0;
    #1;
    outs = {tx_valid, tx_last, rd_en, rd_done, len_err, busy, tx_data, tx_flags, rd_addr};
    total++;
    if (!ok || outs !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: got held=%b outs=%h, want 1 0", ok, outs);
    end
    push_exp(8'h77, f, f.size());
    @(posedge clk); #1;
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    wait_done(done0 + 1, 200, ok);
    total++;
    if (!ok || done_cnt - done0 !== 1) begin
      bad++;
      $display("[TB] FAIL restart_done: got %0d rd_done pulses, want 1", done_cnt - done0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin
        bad++;
        $display("[TB] FAIL restart_byte: got nothing, want %h", e.data);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if ({o.last, o.data, o.flags} !== e) begin
          bad++;
          $display("[TB] FAIL restart_byte: got last=%b data=%h flags=%h, want last=%b data=%h flags=%h",
                   o.last, o.data, o.flags, e.last, e.data, e.flags);
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    tx_ready = 1'b0;
    abort    = 1'b0;
    #2 reset_n = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_len_err();
    test_abort();
    test_back_to_back();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
